// File: rtl/im_refill_if.sv
// Refill bus bundle: Icache-side request/return and instruction-memory port.
// slave: refill controller side; master: Icache plus memory side.
interface im_refill_if #(
   parameter int DATA_SIZE = 32
);
   logic                 IM_enable;
   logic [DATA_SIZE-1:0] IM_address;
   logic                 ready;
   logic [DATA_SIZE-1:0] DataIn;
   logic                 busy;
   logic                 line_done;
   logic                 mem_req;
   logic [DATA_SIZE-1:0] mem_addr;
   logic                 mem_gnt;
   logic                 mem_rvalid;
   logic [DATA_SIZE-1:0] mem_rdata;
   logic                 timeout_err;
   logic [63:0]          refill_cnt;

   modport slave (
      input  IM_enable, IM_address, mem_gnt, mem_rvalid, mem_rdata,
      output ready, DataIn, busy, line_done, mem_req, mem_addr,
             timeout_err, refill_cnt
   );

   modport master (
      output IM_enable, IM_address, mem_gnt, mem_rvalid, mem_rdata,
      input  ready, DataIn, busy, line_done, mem_req, mem_addr,
             timeout_err, refill_cnt
   );
endinterface

// File: rtl/im_refill_ctrl.sv
// Icache line refill controller: fetches LINE_WORDS words in ascending order.
// Ports: clk, rst (sync, active-high), bus (im_refill_if.slave).
module im_refill_ctrl #(
   parameter int DATA_SIZE  = 32,
   parameter int LINE_WORDS = 4,
   parameter int TIMEOUT    = 255
) (
   input logic        clk,
   input logic        rst,
   im_refill_if.slave bus
);
   localparam int WCW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

   typedef enum logic [2:0] {
      IDLE, REQ, WAIT, RESP, DONE
   } state_t;

   state_t               state, state_nx;
   logic [DATA_SIZE-1:0] base_q;
   logic [WCW-1:0]       word_cnt;
   logic [7:0]           wait_cnt;
   logic [DATA_SIZE-1:0] data_q;
   logic                 terr_q;
   logic [63:0]          cnt_q;
   logic                 last_word;
   logic                 expire;

   assign last_word = (word_cnt == WCW'(LINE_WORDS - 1));
   assign expire    = (wait_cnt == 8'(TIMEOUT));

   assign bus.mem_req     = (state == REQ);
   assign bus.mem_addr    = base_q + (DATA_SIZE'(word_cnt) << 2);
   assign bus.ready       = (state == RESP);
   assign bus.busy        = (state != IDLE);
   assign bus.line_done   = (state == DONE);
   assign bus.DataIn      = data_q;
   assign bus.timeout_err = terr_q;
   assign bus.refill_cnt  = cnt_q;

   // rvalid is checked before expiry so a reply on the last cycle wins.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (bus.IM_enable) state_nx = REQ;
         REQ:  if (bus.mem_gnt) state_nx = WAIT;
         WAIT: begin
            if (bus.mem_rvalid) state_nx = RESP;
            else if (expire)    state_nx = REQ;
         end
         RESP: state_nx = last_word ? DONE : REQ;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         base_q   <= '0;
         word_cnt <= '0;
         wait_cnt <= '0;
         data_q   <= '0;
         terr_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && bus.IM_enable) begin
            // Line-aligned base; the line always starts at word 0.
            base_q   <= bus.IM_address & ~DATA_SIZE'(15);
            word_cnt <= '0;
         end
         if (state == REQ && bus.mem_gnt)
            wait_cnt <= '0;
         if (state == WAIT) begin
            if (bus.mem_rvalid)
               data_q <= bus.mem_rdata;
            else if (expire)
               terr_q <= 1'b1;
            else
               wait_cnt <= wait_cnt + 8'd1;
         end
         if (state == RESP && !last_word)
            word_cnt <= word_cnt + WCW'(1);
         if (state == DONE)
            cnt_q <= cnt_q + 64'd1;
      end
   end
endmodule

// File: tb/tb_im_refill_ctrl.sv
// Self-checking bench for im_refill_ctrl with a scoreboard of refill words.
// Drives the Icache request and models an instruction memory responder.
module tb_im_refill_ctrl;
   localparam int DW = 32;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   im_refill_if #(.DATA_SIZE(DW)) mif ();

   im_refill_ctrl #(
      .DATA_SIZE(DW), .LINE_WORDS(4), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .bus(mif)
   );

   int tests = 0;
   int fails = 0;
   int done_count = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] reqs[$];
   int            rcyc[$];
   logic [63:0]   rmask;
   int            done_cyc;
   int            busy_bad;

   // memory responder configuration, armed by bumping a generation count
   logic [DW-1:0] hold_addr = '0;
   int            hold_dly = 0;
   int            hold_gen = 0;
   logic [DW-1:0] stall_addr = '0;
   int            stall_n = 0;
   int            stall_gen = 0;

   // responder private state
   logic          pend = 1'b0;
   logic [DW-1:0] pend_addr = '0;
   int            dly = 0;
   int            hold_seen = 0;
   int            stall_seen = 0;
   int            stall_cnt = 0;

   function automatic logic [DW-1:0] mdata(input logic [DW-1:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard check on ready, then memory responder
   always @(negedge clk) begin
      if (mif.ready) begin
         if (exp_q.size() == 0)
            chk("ready_with_empty_scoreboard", 64'(exp_q.size()), 64'd1);
         else
            chk("refill_word", 64'(mif.DataIn), 64'(exp_q.pop_front()));
      end
      if (mif.line_done) done_count++;

      mif.mem_rvalid = 1'b0;
      mif.mem_rdata  = 32'hDEAD_BEEF;
      if (pend) begin
         if (dly == 0) begin
            mif.mem_rvalid = 1'b1;
            mif.mem_rdata  = mdata(pend_addr);
            pend = 1'b0;
         end else begin
            dly--;
         end
      end
      if (stall_gen != stall_seen) begin
         stall_seen = stall_gen;
         stall_cnt  = stall_n;
      end
      mif.mem_gnt = 1'b1;
      if (mif.mem_req && mif.mem_addr == stall_addr && stall_cnt > 0) begin
         mif.mem_gnt = 1'b0;
         stall_cnt--;
      end
      if (mif.mem_req && mif.mem_gnt) begin
         pend      = 1'b1;
         pend_addr = mif.mem_addr;
         dly       = 0;
         if (hold_gen != hold_seen && mif.mem_addr == hold_addr) begin
            dly       = hold_dly;
            hold_seen = hold_gen;
         end
      end
   end

   // Issue one request at cycle 0 and run to line_done (bounded).
   task automatic run_line(input logic [DW-1:0] addr, input int pulse_c,
                           input logic [DW-1:0] pulse_addr);
      logic [DW-1:0] b;
      b = addr & ~32'hF;
      reqs.delete();
      rcyc.delete();
      rmask    = '0;
      done_cyc = -1;
      busy_bad = 0;
      mif.IM_enable  = 1'b1;
      mif.IM_address = addr;
      for (int i = 0; i < 4; i++)
         exp_q.push_back(mdata(b + 32'(i) * 4));
      for (int c = 1; c <= 150 && done_cyc < 0; c++) begin
         step();
         mif.IM_enable  = (c == pulse_c);
         mif.IM_address = (c == pulse_c) ? pulse_addr : addr;
         if (mif.mem_req) begin
            reqs.push_back(mif.mem_addr);
            rcyc.push_back(c);
         end
         if (mif.ready && c < 64) rmask[c] = 1'b1;
         if (!mif.busy) busy_bad++;
         if (mif.line_done) done_cyc = c;
      end
      mif.IM_enable = 1'b0;
      chk("line_done_seen", 64'(done_cyc >= 0), 64'd1);
      step();
   endtask

   initial begin
      logic [DW-1:0] b;
      logic [DW-1:0] exp_a[5];
      int n8, f8, l8, d0, bad;
      logic found;

      mif.IM_enable  = 1'b0;
      mif.IM_address = '0;
      repeat (3) step();
      chk("rst_busy",        64'(mif.busy),        64'd0);
      chk("rst_ready",       64'(mif.ready),       64'd0);
      chk("rst_mem_req",     64'(mif.mem_req),     64'd0);
      chk("rst_line_done",   64'(mif.line_done),   64'd0);
      chk("rst_DataIn",      64'(mif.DataIn),      64'd0);
      chk("rst_timeout_err", 64'(mif.timeout_err), 64'd0);
      chk("rst_refill_cnt",  mif.refill_cnt,       64'd0);
      rst = 1'b0;
      step();

      // best case
      run_line(32'h0000_1238, 0, '0);
      chk("best_nreq", 64'(reqs.size()), 64'd4);
      for (int i = 0; i < 4; i++)
         chk("best_addr", 64'((i < reqs.size()) ? reqs[i] : 'x),
             64'(32'h1230 + 32'(i) * 4));
      chk("best_ready_cycles", rmask, 64'h1248);
      chk("best_done_cycle", 64'(done_cyc), 64'd13);
      chk("best_busy", 64'(busy_bad), 64'd0);
      chk("best_refill_cnt", mif.refill_cnt, 64'd1);
      chk("best_DataIn_held", 64'(mif.DataIn), 64'(mdata(32'h123C)));

      // rvalid on the very cycle the wait counter reaches TIMEOUT
      hold_addr = 32'h2004;
      hold_dly  = TO;
      hold_gen++;
      run_line(32'h0000_2000, 0, '0);
      chk("sim_nreq", 64'(reqs.size()), 64'd4);
      chk("sim_done_cycle", 64'(done_cyc), 64'(13 + TO));
      chk("sim_timeout_err", 64'(mif.timeout_err), 64'd0);
      chk("sim_refill_cnt", mif.refill_cnt, 64'd2);

      // backpressure on word 2
      stall_addr = 32'h3008;
      stall_n    = 5;
      stall_gen++;
      run_line(32'h0000_3004, 0, '0);
      n8 = 0; f8 = -1; l8 = -1;
      foreach (reqs[i]) begin
         if (reqs[i] == 32'h3008) begin
            n8++;
            if (f8 < 0) f8 = rcyc[i];
            l8 = rcyc[i];
         end
      end
      chk("bp_held_cycles", 64'(n8), 64'd6);
      chk("bp_contiguous", 64'(l8 - f8), 64'd5);
      chk("bp_nreq", 64'(reqs.size()), 64'd9);
      chk("bp_done_cycle", 64'(done_cyc), 64'd18);
      chk("bp_refill_cnt", mif.refill_cnt, 64'd3);

      // IM_enable while busy
      d0 = done_count;
      run_line(32'h0000_4000, 5, 32'h0000_9990);
      repeat (20) step();
      chk("busy_pulse_done_count", 64'(done_count - d0), 64'd1);
      chk("busy_pulse_nreq", 64'(reqs.size()), 64'd4);
      chk("busy_pulse_idle", 64'(mif.busy), 64'd0);
      chk("busy_pulse_refill_cnt", mif.refill_cnt, 64'd4);

      // timeout on word 1, then normal completion
      hold_addr = 32'h5004;
      hold_dly  = 1000;
      hold_gen++;
      run_line(32'h0000_500C, 0, '0);
      exp_a[0] = 32'h5000; exp_a[1] = 32'h5004; exp_a[2] = 32'h5004;
      exp_a[3] = 32'h5008; exp_a[4] = 32'h500C;
      chk("to_nreq", 64'(reqs.size()), 64'd5);
      for (int i = 0; i < 5; i++)
         chk("to_addr", 64'((i < reqs.size()) ? reqs[i] : 'x), 64'(exp_a[i]));
      chk("to_timeout_err", 64'(mif.timeout_err), 64'd1);
      chk("to_refill_cnt", mif.refill_cnt, 64'd5);

      // reset during WAIT of word 2, late rvalid afterwards
      b = 32'h0000_7700;
      hold_addr = b + 8;
      hold_dly  = 3;
      hold_gen++;
      mif.IM_enable  = 1'b1;
      mif.IM_address = b;
      exp_q.push_back(mdata(b));
      exp_q.push_back(mdata(b + 4));
      step();
      mif.IM_enable = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
         step();
         found = mif.mem_req && (mif.mem_addr == b + 8);
      end
      chk("rstw_reach_word2", 64'(found), 64'd1);
      step();
      chk("rstw_in_wait", 64'(mif.busy && !mif.mem_req), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstw_busy", 64'(mif.busy), 64'd0);
      chk("rstw_mem_req", 64'(mif.mem_req), 64'd0);
      chk("rstw_timeout_err", 64'(mif.timeout_err), 64'd0);
      chk("rstw_refill_cnt", mif.refill_cnt, 64'd0);
      chk("rstw_scoreboard_empty", 64'(exp_q.size()), 64'd0);
      bad = 0;
      repeat (6) begin
         step();
         if (mif.ready || mif.busy || mif.line_done) bad++;
      end
      chk("rstw_late_rvalid_ignored", 64'(bad), 64'd0);
      chk("rstw_DataIn", 64'(mif.DataIn), 64'd0);

      // fresh request after reset starts at offset 0
      run_line(32'h0000_6608, 0, '0);
      chk("post_first_addr", 64'((reqs.size() > 0) ? reqs[0] : 'x),
          64'(32'h6600));
      chk("post_ready_cycles", rmask, 64'h1248);
      chk("post_refill_cnt", mif.refill_cnt, 64'd1);
      chk("post_timeout_err", 64'(mif.timeout_err), 64'd0);
      chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog tests=%0d", tests);
      $fatal(1, "watchdog expired");
   end
endmodule
